pipelined_shifter: RTL and testbench



---
 rtl/pipelined_shifter.sv | 186 ++++++++++++++++++
 tb/tb_pipelined_shifter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_shifter.sv
// rtl/pipelined_shifter.sv - pipelined shl/lshr/ashr/rotl shifter with valid/ready handshake
// Optional O_lost output enabled by defining PIPELINED_SHIFTER_LOST_EN.
module pipelined_shifter #(
    parameter int WIDTH = 8,
    parameter int PIPE  = 2
) (
    input  logic             CLK,
    input  logic             ASYNCRESETN,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic [1:0]       MODE,
    input  logic             I_valid,
    output logic             I_ready,
    output logic [WIDTH-1:0] O,
    output logic             O_valid,
    input  logic             O_ready
`ifdef PIPELINED_SHIFTER_LOST_EN
    ,
    output logic             O_lost
`endif
);

    localparam int L = $clog2(WIDTH);

    localparam logic [1:0] M_SHL  = 2'd0;
    localparam logic [1:0] M_LSHR = 2'd1;
    localparam logic [1:0] M_ASHR = 2'd2;
    localparam logic [1:0] M_ROTL = 2'd3;

    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input logic [1:0] m,
                                                  input int s);
        case (m)
            M_SHL:   return d << s;
            M_LSHR:  return d >> s;
            M_ASHR:  return WIDTH'($signed(d) >>> s);
            default: return (d << s) | (d >> (WIDTH - s));
        endcase
    endfunction

`ifdef PIPELINED_SHIFTER_LOST_EN
    // Bits that fall off the end in one partial shift step of size s.
    function automatic logic step_lost(input logic [WIDTH-1:0] d,
                                       input logic [1:0] m,
                                       input int s);
        logic [WIDTH-1:0] ones;
        ones = '1;
        case (m)
            M_SHL:   return |(d & ~(ones >> s));
            M_LSHR:  return |(d & ~(ones << s));
            M_ASHR:  return |((d ^ {WIDTH{d[WIDTH-1]}}) & ~(ones << s));
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic range_lost(input logic [WIDTH-1:0] d, input logic [1:0] m);
        case (m)
            M_SHL, M_LSHR: return |d;
            M_ASHR:        return d != {WIDTH{d[WIDTH-1]}};
            default:       return 1'b0;
        endcase
    endfunction
`endif

    logic adv;
    logic rdy_q;

    logic [WIDTH-1:0] d_o   [PIPE];
    logic [1:0]       m_o   [PIPE];
    logic [L-1:0]     a_o   [PIPE];
    logic             oor_o [PIPE];
    logic             v_o   [PIPE];
`ifdef PIPELINED_SHIFTER_LOST_EN
    logic             l_o   [PIPE];
`endif

    assign O_valid = v_o[PIPE-1];
    assign O       = d_o[PIPE-1];
    assign adv     = !O_valid || O_ready;
    assign I_ready = rdy_q && adv;
`ifdef PIPELINED_SHIFTER_LOST_EN
    assign O_lost  = l_o[PIPE-1];
`endif

    // Keeps I_ready low until the first clock edge after reset is released.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            rdy_q <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
        end
    end

    for (genvar k = 0; k < PIPE; k++) begin : g_stage
        localparam int LO = (k * L) / PIPE;
        localparam int HI = ((k + 1) * L) / PIPE;
        localparam int NB = HI - LO;

        logic [WIDTH-1:0] di, dn, dq;
        logic [1:0]       mi, mq;
        logic [L-1:0]     ai, aq;
        logic             oi, oq;
        logic             vi, vq;
        logic [WIDTH-1:0] dc [NB+1];
`ifdef PIPELINED_SHIFTER_LOST_EN
        logic             li, ln, lq;
        logic             lc [NB+1];
`endif

        if (k == 0) begin : g_head
            assign di = I0;
            assign mi = MODE;
            assign ai = I1[L-1:0];
            assign oi = |I1[WIDTH-1:L];
            assign vi = I_valid && rdy_q;
`ifdef PIPELINED_SHIFTER_LOST_EN
            assign li = oi && range_lost(I0, MODE);
`endif
        end else begin : g_body
            assign di = d_o[k-1];
            assign mi = m_o[k-1];
            assign ai = a_o[k-1];
            assign oi = oor_o[k-1];
            assign vi = v_o[k-1];
`ifdef PIPELINED_SHIFTER_LOST_EN
            assign li = l_o[k-1];
`endif
        end

        // Each stage applies only its own slice of the amount bits, low bits first.
        assign dc[0] = di;
`ifdef PIPELINED_SHIFTER_LOST_EN
        assign lc[0] = li;
`endif
        for (genvar j = 0; j < NB; j++) begin : g_bit
            assign dc[j+1] = ai[LO+j] ? shift_by(dc[j], mi, 2 ** (LO + j)) : dc[j];
`ifdef PIPELINED_SHIFTER_LOST_EN
            assign lc[j+1] = lc[j] || (ai[LO+j] && step_lost(dc[j], mi, 2 ** (LO + j)));
`endif
        end

        // Out-of-range amounts override the partial shifts once all slices are applied.
        if (k == PIPE - 1) begin : g_tail
            assign dn = (oi && mi != M_ROTL)
                      ? ((mi == M_ASHR) ? {WIDTH{di[WIDTH-1]}} : '0)
                      : dc[NB];
        end else begin : g_pass
            assign dn = dc[NB];
        end
`ifdef PIPELINED_SHIFTER_LOST_EN
        assign ln = lc[NB];
`endif

        always_ff @(posedge CLK or negedge ASYNCRESETN) begin
            if (!ASYNCRESETN) begin
                vq <= 1'b0;
                dq <= '0;
                mq <= '0;
                aq <= '0;
                oq <= 1'b0;
`ifdef PIPELINED_SHIFTER_LOST_EN
                lq <= 1'b0;
`endif
            end else if (adv) begin
                vq <= vi;
                dq <= dn;
                mq <= mi;
                aq <= ai;
                oq <= oi;
`ifdef PIPELINED_SHIFTER_LOST_EN
                lq <= ln;
`endif
            end
        end

        assign d_o[k]   = dq;
        assign m_o[k]   = mq;
        assign a_o[k]   = aq;
        assign oor_o[k] = oq;
        assign v_o[k]   = vq;
`ifdef PIPELINED_SHIFTER_LOST_EN
        assign l_o[k]   = lq;
`endif
    end

endmodule

// File: tb/tb_pipelined_shifter.sv
// tb/tb_pipelined_shifter.sv - directed vector bench for pipelined_shifter (WIDTH=8, PIPE=2)
module tb_pipelined_shifter;

    logic       clk;
    logic       rst_n;
    logic [7:0] I0, I1, O;
    logic [1:0] MODE;
    logic       I_valid, I_ready, O_valid, O_ready;
`ifdef PIPELINED_SHIFTER_LOST_EN
    logic       O_lost;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] i0;
        logic [7:0] i1;
        logic [7:0] o;
        logic       lost;
    } vec_t;

    vec_t tab[$];
    vec_t ops[$];

    pipelined_shifter #(.WIDTH(8), .PIPE(2)) dut (
        .CLK(clk),
        .ASYNCRESETN(rst_n),
        .I0(I0),
        .I1(I1),
        .MODE(MODE),
        .I_valid(I_valid),
        .I_ready(I_ready),
        .O(O),
        .O_valid(O_valid),
        .O_ready(O_ready)
`ifdef PIPELINED_SHIFTER_LOST_EN
        ,
        .O_lost(O_lost)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] m, input logic [7:0] a, input logic [7:0] n,
                                input logic [7:0] o, input logic l);
        vec_t v;
        v.mode = m; v.i0 = a; v.i1 = n; v.o = o; v.lost = l;
        return v;
    endfunction

    // Bit-at-a-time reference: shifting past the width falls out naturally.
    function automatic vec_t ref_op(input logic [1:0] m, input logic [7:0] a, input logic [7:0] n);
        logic [7:0] r;
        logic       l;
        r = a;
        l = 1'b0;
        if (m == 2'd3) begin
            for (int j = 0; j < int'(n % 8); j++) r = {r[6:0], r[7]};
        end else begin
            for (int j = 0; j < int'(n); j++) begin
                case (m)
                    2'd0:    begin l = l | r[7];        r = {r[6:0], 1'b0}; end
                    2'd1:    begin l = l | r[0];        r = {1'b0, r[7:1]}; end
                    default: begin l = l | (r[0] ^ r[7]); r = {r[7], r[7:1]}; end
                endcase
            end
        end
        return mk(m, a, n, r, l);
    endfunction

    task automatic check_out(input string name, input vec_t v);
        chk({name, "_O"}, 32'(O), 32'(v.o));
`ifdef PIPELINED_SHIFTER_LOST_EN
        chk({name, "_lost"}, 32'(O_lost), 32'(v.lost));
`endif
    endtask

    task automatic run_single(input vec_t v, input string name);
        @(negedge clk);
        MODE = v.mode; I0 = v.i0; I1 = v.i1; I_valid = 1'b1; O_ready = 1'b1;
        #1;
        chk({name, "_ready"}, 32'(I_ready), 32'd1);
        @(negedge clk);
        I_valid = 1'b0; MODE = v.mode + 2'd1; I0 = ~v.i0; I1 = v.i1 + 8'd1;
        #1;
        chk({name, "_early"}, 32'(O_valid), 32'd0);
        @(negedge clk);
        #1;
        chk({name, "_valid"}, 32'(O_valid), 32'd1);
        check_out(name, v);
    endtask

    task automatic run_stream(input int stall_at, input int stall_len, input string tag);
        int acc = 0;
        int got = 0;
        logic [7:0] held = '0;
        for (int c = 0; c < 80 && got < ops.size(); c++) begin
            @(negedge clk);
            O_ready = !(c >= stall_at && c < stall_at + stall_len);
            if (acc < ops.size()) begin
                I_valid = 1'b1; MODE = ops[acc].mode; I0 = ops[acc].i0; I1 = ops[acc].i1;
            end else begin
                I_valid = 1'b0;
            end
            #2;
            if (!O_ready) begin
                chk($sformatf("%s_stall_ready_c%0d", tag, c), 32'(I_ready), 32'd0);
                chk($sformatf("%s_stall_valid_c%0d", tag, c), 32'(O_valid), 32'd1);
                if (c == stall_at) held = O;
                else chk($sformatf("%s_stall_hold_c%0d", tag, c), 32'(O), 32'(held));
            end
            if (O_valid && O_ready) begin
                check_out($sformatf("%s_res%0d", tag, got), ops[got]);
                if (stall_len == 0)
                    chk($sformatf("%s_cycle%0d", tag, got), 32'(c), 32'(got + 2));
                got++;
            end
            if (I_valid && I_ready) acc++;
        end
        I_valid = 1'b0;
        chk({tag, "_count"}, 32'(got), 32'(ops.size()));
    endtask

    initial begin
        int stale;
        rst_n = 1'b0; I_valid = 1'b0; O_ready = 1'b0; I0 = '0; I1 = '0; MODE = '0;

        tab.push_back(mk(2'd0, 8'h81, 8'd1,   8'h02, 1'b1));
        tab.push_back(mk(2'd2, 8'h90, 8'd2,   8'hE4, 1'b1));
        tab.push_back(mk(2'd1, 8'h90, 8'd2,   8'h24, 1'b0));
        tab.push_back(mk(2'd0, 8'hFF, 8'd9,   8'h00, 1'b1));
        tab.push_back(mk(2'd1, 8'h80, 8'd8,   8'h00, 1'b1));
        tab.push_back(mk(2'd2, 8'h80, 8'd200, 8'hFF, 1'b1));
        tab.push_back(mk(2'd2, 8'h7F, 8'd200, 8'h00, 1'b1));
        tab.push_back(mk(2'd3, 8'h81, 8'd9,   8'h03, 1'b0));
        tab.push_back(mk(2'd0, 8'hA5, 8'd0,   8'hA5, 1'b0));
        tab.push_back(mk(2'd1, 8'h5A, 8'd0,   8'h5A, 1'b0));
        tab.push_back(mk(2'd2, 8'hC3, 8'd0,   8'hC3, 1'b0));
        tab.push_back(mk(2'd3, 8'h3C, 8'd0,   8'h3C, 1'b0));
        tab.push_back(mk(2'd3, 8'hB4, 8'd3,   8'hA5, 1'b0));
        tab.push_back(mk(2'd2, 8'hF0, 8'd4,   8'hFF, 1'b1));
        tab.push_back(mk(2'd1, 8'hF0, 8'd4,   8'h0F, 1'b0));
        tab.push_back(mk(2'd0, 8'h0F, 8'd4,   8'hF0, 1'b0));
        tab.push_back(mk(2'd2, 8'hC3, 8'd7,   8'hFF, 1'b1));
        tab.push_back(mk(2'd0, 8'h00, 8'd255, 8'h00, 1'b0));
        tab.push_back(mk(2'd3, 8'h01, 8'd7,   8'h80, 1'b0));
        tab.push_back(mk(2'd1, 8'h01, 8'd16,  8'h00, 1'b1));
        tab.push_back(mk(2'd0, 8'h40, 8'd1,   8'h80, 1'b0));
        tab.push_back(mk(2'd2, 8'h40, 8'd6,   8'h01, 1'b0));

        #12;
        chk("rst_O", 32'(O), 32'd0);
        chk("rst_valid", 32'(O_valid), 32'd0);
        chk("rst_ready", 32'(I_ready), 32'd0);
        #10;
        rst_n = 1'b1;
        #1;
        chk("rst_ready_before_edge", 32'(I_ready), 32'd0);
        @(negedge clk);
        chk("rst_ready_after_edge", 32'(I_ready), 32'd1);

        for (int i = 0; i < tab.size(); i++) run_single(tab[i], $sformatf("vec%0d", i));

        ops.delete();
        ops.push_back(mk(2'd0, 8'h03, 8'd2, 8'h0C, 1'b0));
        ops.push_back(mk(2'd1, 8'hC0, 8'd3, 8'h18, 1'b0));
        ops.push_back(mk(2'd2, 8'h84, 8'd1, 8'hC2, 1'b1));
        ops.push_back(mk(2'd3, 8'h12, 8'd4, 8'h21, 1'b0));
        ops.push_back(mk(2'd0, 8'h11, 8'd3, 8'h88, 1'b0));
        ops.push_back(mk(2'd1, 8'hFF, 8'd7, 8'h01, 1'b1));
        run_stream(3, 4, "stall");

        ops.delete();
        for (int k = 0; k < 20; k++)
            ops.push_back(ref_op(2'(k % 4), 8'(k * 37 + 5), 8'((k * 13) % 23)));
        run_stream(-10, 0, "full");

        @(negedge clk);
        MODE = 2'd0; I0 = 8'h81; I1 = 8'd1; I_valid = 1'b1; O_ready = 1'b1;
        @(negedge clk);
        MODE = 2'd3; I0 = 8'h0F; I1 = 8'd4;
        @(posedge clk);
        #2;
        I_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(O_valid), 32'd0);
        chk("midrst_O", 32'(O), 32'd0);
        chk("midrst_ready", 32'(I_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst_ready_release", 32'(I_ready), 32'd0);
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #2;
            if (O_valid) stale++;
        end
        chk("midrst_stale", 32'(stale), 32'd0);
        run_single(mk(2'd0, 8'h05, 8'd3, 8'h28, 1'b0), "post_rst");

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
